// File: rtl/sha512_arbiter.sv
// Round-robin owner of a shared sha512 engine: grants one requester per message, sequences the
// engine (enable, start, word feed, process, wait, done, clear) and returns the latched digest.
module sha512_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned WordW  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*128-1:0]   msg_len_i,
  input  logic [NumReq-1:0]       wvalid_i,
  input  logic [NumReq*WordW-1:0] wdata_i,
  output logic [NumReq-1:0]       wready_o,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       done_o,
  output logic [511:0]            digest_o,
  output logic                    sha_en_o,
  output logic                    hash_start_o,
  output logic                    hash_process_o,
  output logic [127:0]            message_length_o,
  output logic                    eng_rvalid_o,
  output logic [WordW-1:0]        eng_rdata_o,
  input  logic                    eng_rready_i,
  input  logic                    hash_done_i,
  input  logic [511:0]            eng_digest_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StFeed,
    StProc,
    StWait,
    StDone,
    StClear
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [127:0]    len_q, len_d;
  logic [128:0]    left_q, left_d;
  logic [511:0]    digest_q, digest_d;

  logic [127:0]     len_arr   [NumReq];
  logic [WordW-1:0] wdata_arr [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign len_arr[g]   = msg_len_i[g*128 +: 128];
    assign wdata_arr[g] = wdata_i[g*WordW +: WordW];
  end

  // Round-robin pick: first pending requester strictly after rr_q, wrapping.
  logic [IdxW-1:0] pick;
  logic            pick_vld;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumReq);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Word count rounds the bit length up to whole 64-bit words without overflow.
  logic [128:0] len_sum;
  assign len_sum = {1'b0, len_arr[pick]} + 129'd63;

  logic abort;
  assign abort = ~req_i[owner_q];

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    len_d    = len_q;
    left_d   = left_q;
    digest_d = digest_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          owner_d = pick;
          len_d   = len_arr[pick];
          left_d  = len_sum >> 6;
          state_d = StStart;
        end
      end
      StStart: begin
        if (abort)                state_d = StClear;
        else if (left_q == '0)    state_d = StProc;
        else                      state_d = StFeed;
      end
      StFeed: begin
        if (abort) begin
          state_d = StClear;
        end else if (wvalid_i[owner_q] && eng_rready_i) begin
          left_d = left_q - 129'd1;
          if (left_q == 129'd1) state_d = StProc;
        end
      end
      StProc: begin
        state_d = abort ? StClear : StWait;
      end
      StWait: begin
        if (abort) begin
          state_d = StClear;
        end else if (hash_done_i) begin
          digest_d = eng_digest_i;
          state_d  = StDone;
        end
      end
      StDone: begin
        rr_d    = owner_q;
        state_d = StClear;
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic busy;
  assign busy = (state_q != StIdle) && (state_q != StClear);

  always_comb begin
    gnt_o            = '0;
    done_o           = '0;
    wready_o         = '0;
    sha_en_o         = busy;
    hash_start_o     = (state_q == StStart);
    hash_process_o   = (state_q == StProc);
    message_length_o = busy ? len_q : '0;
    eng_rvalid_o     = 1'b0;
    eng_rdata_o      = '0;
    digest_o         = digest_q;
    if (busy) gnt_o[owner_q] = 1'b1;
    if (state_q == StDone) done_o[owner_q] = 1'b1;
    if (state_q == StFeed) begin
      eng_rvalid_o      = wvalid_i[owner_q];
      eng_rdata_o       = wdata_arr[owner_q];
      wready_o[owner_q] = eng_rready_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rr_q     <= IdxW'(NumReq - 1);
      owner_q  <= '0;
      len_q    <= '0;
      left_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      len_q    <= len_d;
      left_q   <= left_d;
      digest_q <= digest_d;
    end
  end

endmodule
